map_neighbor_scanner: RTL

- Upstream feeder for the valid-move detector.
- Takes a sprite pixel position (Pac-Man or ghost) and reads the four neighbouring tiles from the map block RAM.
- Produces the one-hot valid-move mask: right = 4'b0001, up = 4'b0010, down = 4'b0100, left = 4'b1000.
- Sequential: one registered scan per start request, over a synchronous 1-cycle-latency BRAM port.

---
 rtl/game_map_pkg.sv | 16 +
 rtl/tile_neighbor_addr.sv | 34 +++
 rtl/map_neighbor_scanner.sv | 94 +++++++++
 3 files changed

// File: rtl/game_map_pkg.sv
// game_map_pkg: shared map constants, tile codes, directions and scan state encoding.
package game_map_pkg;
  localparam int MAP_W_DEF = 40;
  localparam int MAP_H_DEF = 30;
  localparam int TILE_SHIFT_DEF = 4;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP = 4'b0010;
  localparam logic [3:0] DIR_DOWN = 4'b0100;
  localparam logic [3:0] DIR_LEFT = 4'b1000;
  typedef enum logic [1:0] {TILE_EMPTY = 2'b00, TILE_WALL = 2'b01, TILE_DOT = 2'b10} tile_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} scan_state_t;
  // Fixed probe order: right, left, up, down.
  function automatic logic [3:0] probe_dir(input logic [1:0] k);
    return k == 2'd0 ? DIR_RIGHT : k == 2'd1 ? DIR_LEFT : k == 2'd2 ? DIR_UP : DIR_DOWN;
  endfunction
endpackage

// File: rtl/tile_neighbor_addr.sv
// tile_neighbor_addr: neighbour tile address and bounds flag; MAP_WRAP_EN enables horizontal tunnel wrap.
module tile_neighbor_addr import game_map_pkg::*; #(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF,
  parameter int TX_W = 7,
  parameter int TY_W = 6,
  parameter int ADDR_W = 11
) (
  input  logic [TX_W-1:0]   tx,
  input  logic [TY_W-1:0]   ty,
  input  logic [3:0]        dir,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds
);
  localparam logic [TX_W:0] XW = (TX_W+1)'(MAP_W);
  localparam logic [TY_W:0] YH = (TY_W+1)'(MAP_H);
  localparam logic [TX_W:0] X1 = (TX_W+1)'(1);
  localparam logic [TY_W:0] Y1 = (TY_W+1)'(1);
  logic [TX_W:0] nx;
  logic [TY_W:0] ny;
  logic sprite_ok;
  always_comb begin
    sprite_ok = {1'b0, tx} < XW && {1'b0, ty} < YH;
    nx = dir == DIR_RIGHT ? {1'b0, tx} + X1 : dir == DIR_LEFT ? {1'b0, tx} - X1 : {1'b0, tx};
    ny = dir == DIR_DOWN ? {1'b0, ty} + Y1 : dir == DIR_UP ? {1'b0, ty} - Y1 : {1'b0, ty};
`ifdef MAP_WRAP_EN
    nx = sprite_ok && dir == DIR_RIGHT && {1'b0, tx} == XW - X1 ? '0 :
         sprite_ok && dir == DIR_LEFT && tx == '0 ? XW - X1 : nx;
`endif
    // Underflow wraps to all-ones, which the range check rejects.
    in_bounds = sprite_ok && nx < XW && ny < YH;
    addr = ADDR_W'(in_bounds ? ny : {1'b0, ty}) * ADDR_W'(MAP_W) + ADDR_W'(in_bounds ? nx : {1'b0, tx});
  end
endmodule

// File: rtl/map_neighbor_scanner.sv
// map_neighbor_scanner: reads the four neighbour tiles of a sprite over a 1-cycle BRAM and builds the valid-move mask.
// Optional horizontal tunnel wrap via MAP_WRAP_EN (see tile_neighbor_addr).
module map_neighbor_scanner import game_map_pkg::*; #(
  parameter int TILE_SHIFT = TILE_SHIFT_DEF,
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF,
  parameter int ADDR_W = 11,
  parameter int TILE_W = 2,
  parameter logic [TILE_W-1:0] WALL_CODE = TILE_WALL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [10:0]       curr_pos_x,
  input  logic [9:0]        curr_pos_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [TILE_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic [3:0]        valid_moves
);
  localparam int TX_W = 11 - TILE_SHIFT;
  localparam int TY_W = 10 - TILE_SHIFT;
  scan_state_t state;
  logic [2:0] idx;
  logic [TX_W-1:0] tx_q, tx_c;
  logic [TY_W-1:0] ty_q, ty_c;
  logic [3:0] ok, acc, cap_bit, dir;
  logic [1:0] cap;
  logic [ADDR_W-1:0] nb_addr;
  logic nb_in, idle;
  assign idle = state == S_IDLE;
  assign tx_c = idle ? TX_W'(curr_pos_x >> TILE_SHIFT) : tx_q;
  assign ty_c = idle ? TY_W'(curr_pos_y >> TILE_SHIFT) : ty_q;
  assign dir = probe_dir(idle ? 2'd0 : idx[1:0]);
  // idx counts edges since accept; data for probe k lands at edge k+2.
  assign cap = 2'(idx - 3'd2);
  assign cap_bit = ok[cap] && mem_rd_data != WALL_CODE ? probe_dir(cap) : 4'b0000;
  tile_neighbor_addr #(.MAP_W(MAP_W), .MAP_H(MAP_H), .TX_W(TX_W), .TY_W(TY_W), .ADDR_W(ADDR_W)) u_addr (
    .tx(tx_c), .ty(ty_c), .dir(dir), .addr(nb_addr), .in_bounds(nb_in)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      tx_q <= '0;
      ty_q <= '0;
      ok <= '0;
      acc <= '0;
      mem_addr <= '0;
      mem_rd_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      valid_moves <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          tx_q <= tx_c;
          ty_q <= ty_c;
          mem_addr <= nb_addr;
          mem_rd_en <= 1'b1;
          busy <= 1'b1;
          ok <= {3'b000, nb_in};
          acc <= '0;
          idx <= 3'd1;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          mem_addr <= nb_addr;
          ok[idx[1:0]] <= nb_in;
          acc <= idx >= 3'd2 ? acc | cap_bit : acc;
          idx <= idx + 3'd1;
          state <= idx == 3'd3 ? S_DRAIN : S_ISSUE;
        end
        S_DRAIN: begin
          mem_rd_en <= 1'b0;
          acc <= acc | cap_bit;
          idx <= idx + 3'd1;
          if (idx == 3'd5) begin
            valid_moves <= acc | cap_bit;
            done <= 1'b1;
            busy <= 1'b0;
            state <= S_DONE;
          end
        end
        default: begin
          done <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
